// File: rtl/fpr_pkg.sv
// Shared constants for the FP register file write-back arbiter.
package fpr_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 32;

  // Requester indices, also the encoding of last_grant.
  localparam logic REQ_LD  = 1'b0;
  localparam logic REQ_FPU = 1'b1;

endpackage

// File: rtl/fpr_scoreboard.sv
// Pending-destination scoreboard: one bit per FPR that is awaiting an FPU
// result. Issue sets a bit, a granted FPU write-back clears it.
module fpr_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              iss_ready,
  input  logic              clr_valid,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] chk_rs,
  input  logic [ADDR_W-1:0] chk_rt,
  output logic              raw_stall,
  output logic [NREGS-1:0]  pending
);

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;

  // A second issue to a still-pending register must wait. When the clear
  // and the issue hit the same register, the issue sees the old bit and is
  // refused, so the clear lands first and the issue retries next cycle.
  assign iss_ready = !pending_q[iss_rd];

  // Stall reflects the registered state only; no forwarding of the value
  // being written this cycle.
  assign raw_stall = pending_q[chk_rs] | pending_q[chk_rt];
  assign pending   = pending_q;

  // Next pending vector: apply the clear, then the set.
  always_comb begin
    pending_d = pending_q;
    if (clr_valid) pending_d[clr_addr] = 1'b0;
    if (iss_valid && iss_ready) pending_d[iss_rd] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending_q <= '0;
    else        pending_q <= pending_d;
  end

endmodule

// File: rtl/fpr_wb_arbiter.sv
// FP register file write-port arbiter between the load/move path (requester 0)
// and the FPU result path (requester 1), with a pending-destination
// scoreboard for WAW blocking and RAW stall reporting.
//
// Handshake: a transfer happens on a rising edge where valid && ready. ready
// is a combinational grant; a requester holds addr/data while valid && !ready.
module fpr_wb_arbiter #(
  parameter int DATA_W = fpr_pkg::DATA_W,
  parameter int ADDR_W = fpr_pkg::ADDR_W,
  parameter int NREGS  = fpr_pkg::NREGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              fpu_valid,
  input  logic [ADDR_W-1:0] fpu_addr,
  input  logic [DATA_W-1:0] fpu_data,
  output logic              fpu_ready,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              iss_ready,
  input  logic [ADDR_W-1:0] chk_rs,
  input  logic [ADDR_W-1:0] chk_rt,
  output logic              raw_stall,
  output logic [NREGS-1:0]  pending,
  output logic              regWr,
  output logic [ADDR_W-1:0] Rw,
  output logic [DATA_W-1:0] busW
);

  import fpr_pkg::*;

  logic              ld_elig;
  logic              fpu_elig;
  logic              grant_ld;
  logic              grant_fpu;
  logic              last_grant_q, last_grant_d;
  logic              regwr_q, regwr_d;
  logic [ADDR_W-1:0] rw_q, rw_d;
  logic [DATA_W-1:0] busw_q, busw_d;

  fpr_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .clr_valid (grant_fpu),
    .clr_addr  (fpu_addr),
    .chk_rs    (chk_rs),
    .chk_rt    (chk_rt),
    .raw_stall (raw_stall),
    .pending   (pending)
  );

  // Eligibility and round-robin grant; a load may not overtake an
  // outstanding FPU write to the same register.
  always_comb begin
    ld_elig   = ld_valid && !pending[ld_addr];
    fpu_elig  = fpu_valid;
    grant_ld  = ld_elig && (!fpu_elig || (last_grant_q == REQ_FPU));
    grant_fpu = fpu_elig && !grant_ld;
  end

  assign ld_ready  = grant_ld;
  assign fpu_ready = grant_fpu;

  // Next-state for the grant history and the registered write port.
  always_comb begin
    last_grant_d = last_grant_q;
    regwr_d      = grant_ld | grant_fpu;
    rw_d         = rw_q;
    busw_d       = busw_q;
    if (grant_fpu) begin
      last_grant_d = REQ_FPU;
      rw_d         = fpu_addr;
      busw_d       = fpu_data;
    end else if (grant_ld) begin
      last_grant_d = REQ_LD;
      rw_d         = ld_addr;
      busw_d       = ld_data;
    end
  end

  // Grant history and write-port registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= REQ_FPU;
      regwr_q      <= 1'b0;
      rw_q         <= '0;
      busw_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      regwr_q      <= regwr_d;
      rw_q         <= rw_d;
      busw_q       <= busw_d;
    end
  end

  assign regWr = regwr_q;
  assign Rw    = rw_q;
  assign busW  = busw_q;

endmodule

// File: doc/fpr_wb_arbiter.md
Name: fpr_wb_arbiter

Overview:
Shares the FP register file's single write port between two requesters: the load/move path (lwc1/mtc1, requester 0) and the multi-cycle FPU result path (requester 1).
Keeps a 32-bit pending scoreboard of FPU destinations, and uses it to:
- block WAW collisions on the write port;
- expose RAW hazards to the decode stall logic.
Drives the register file's write enable, write address and write data from registered outputs. The register file is used with Rd as the write-address select.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register address width
NREGS, 32, number of FP registers (2**ADDR_W)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
ld_valid  in  1  requester 0 (load/move) has a write
ld_addr  in  ADDR_W  requester 0 destination
ld_data  in  DATA_W  requester 0 data
ld_ready  out  1  requester 0 accepted this cycle
fpu_valid  in  1  requester 1 (FPU result) has a write
fpu_addr  in  ADDR_W  requester 1 destination
fpu_data  in  DATA_W  requester 1 data
fpu_ready  out  1  requester 1 accepted this cycle
iss_valid  in  1  FPU op issuing this cycle
iss_rd  in  ADDR_W  destination of issuing FPU op
iss_ready  out  1  issue accepted (combinational)
chk_rs  in  ADDR_W  decode source A
chk_rt  in  ADDR_W  decode source B
raw_stall  out  1  pending[chk_rs] or pending[chk_rt] (combinational)
pending  out  NREGS  scoreboard, bit i = FPR i awaiting FPU result
regWr  out  1  register file write enable (registered)
Rw  out  ADDR_W  register file write address (registered)
busW  out  DATA_W  register file write data (registered)

Behaviour:
- Reset (reset=0, asynchronous):
  - pending=0, regWr=0, Rw=0, busW=0, last_grant=1.
  - In-flight requests are dropped; requesters must re-present after release.
  - Reset mid-operation clears everything on the same edge it is asserted.
- Handshake: a transfer occurs when valid && ready on a rising edge. Requesters hold addr/data stable while valid && !ready.
- Eligibility:
  - Requester 0 is eligible when ld_valid && !pending[ld_addr]. This is WAW protection: a load may not overtake an outstanding FPU write to the same register.
  - Requester 1 is eligible when fpu_valid. It must target a pending register; a result to a non-pending address is still written (no error flag).
- Arbitration:
  - Only one requester is eligible: it is granted.
  - Both are eligible: round-robin, granting the requester that is not last_grant. last_grant updates on every grant.
  - Worst-case wait for an eligible requester is 1 cycle.
- ld_ready and fpu_ready are combinational grants. At most one is high per cycle.
- Write latency: a grant in cycle N produces regWr=1 with Rw/busW = granted addr/data in cycle N+1. regWr=0 in any cycle following a cycle with no grant.
- Scoreboard:
  - iss_ready = !pending[iss_rd]. This stalls a second FPU issue to a still-pending register.
  - iss_valid && iss_ready sets pending[iss_rd] at the edge.
  - A granted FPU transfer clears pending[fpu_addr] at the edge, the same edge the write is registered.
- Simultaneous events:
  - FPU clear of X and issue to X in the same cycle: the issue is refused (iss_ready=0, since pending[X]=1). The clear is applied, and the issue succeeds next cycle.
  - FPU clear of X and issue to Y≠X: both take effect.
- raw_stall is a pure function of the current pending state. A register whose result is being written this cycle still reports stall. Forwarding is out of scope.
- No address is special: FPR 0 is an ordinary register.

Decomposition:
- Package fpr_pkg holds:
  - ADDR_W/DATA_W/NREGS constants;
  - requester index constants REQ_LD=0, REQ_FPU=1.
- One natural sub-module, fpr_scoreboard: the pending vector, set/clear logic, iss_ready and raw_stall.
- The arbiter and output registers stay in the top module.

Test Plan:
- Reset: hold reset=0 with random inputs. Expect regWr=0, Rw=0, busW=0, pending=0, ld_ready=0 while ld_valid=0. Release reset, then ld_valid, ld_addr=3, ld_data=0x3F800000. Expect ld_ready=1 that cycle and regWr=1, Rw=3, busW=0x3F800000 next cycle.
- Round-robin: ld and fpu both valid for 4 cycles (fpu_addr=5 pending, ld_addr=7). Expect grant order LD, FPU, LD, FPU after reset; never both ready.
- WAW block: issue rd=9, then ld_valid with ld_addr=9. Expect ld_ready=0 until the FPU writes 9 (data 0x40490FDB). Expect the FPU write at N+1 and the load write on a later cycle; the final register value is the load data.
- Issue stall/clear collision: pending[12]=1. In the same cycle fpu writes 12 and iss_rd=12. Expect iss_ready=0, pending[12]=0 after the edge. Next cycle iss_ready=1, then pending[12]=1.
- RAW: pending[4]=1, chk_rs=4, chk_rt=6. Expect raw_stall=1. After the FPU grant to 4, expect raw_stall=0 on the following cycle.
- Reset mid-operation: pending=0x0000_1230, regWr=1. Assert reset asynchronously between edges. Expect regWr and pending to go to 0 immediately, without waiting for clk.
